// File: rtl/ika2151_mixacc_if.sv
// ika2151_mixacc_if
//   Bundles the slot-rate sample bus and serial DAC outputs of the IKA2151
//   output mixer. Clock and reset are not part of the bundle.
//
//   Handshake semantics: there is no back-pressure. i_SND_VALID qualifies
//   i_SND/i_CH_MASK for the current slot only, and is consumed on every
//   enabled edge (i_CEN_n == 0). The sink is always ready. o_SH marks the
//   last bit of a channel word on o_SO.
//
//   master : sound source / test driver (drives i_*, observes o_*)
//   slave  : ika2151_mixacc (observes i_*, drives o_*)
interface ika2151_mixacc_if #(
  parameter int CH_N = 2,
  parameter int IN_W = 14
);
  logic            i_CEN_n;
  logic            i_SYNC;
  logic            i_FMT;
  logic            i_SND_VALID;
  logic [CH_N-1:0] i_CH_MASK;
  logic [IN_W-1:0] i_SND;
  logic            i_CLIP_CLR;
  logic            o_SO;
  logic [CH_N-1:0] o_SH;
  logic [CH_N-1:0] o_CLIP;

  modport master (
    output i_CEN_n, i_SYNC, i_FMT, i_SND_VALID, i_CH_MASK, i_SND, i_CLIP_CLR,
    input  o_SO, o_SH, o_CLIP
  );

  modport slave (
    input  i_CEN_n, i_SYNC, i_FMT, i_SND_VALID, i_CH_MASK, i_SND, i_CLIP_CLR,
    output o_SO, o_SH, o_CLIP
  );
endinterface

// File: rtl/ika2151_mixacc.sv
// ika2151_mixacc
//   Multi-channel output accumulator and serial DAC formatter. Per-slot
//   samples are summed into CH_N accumulators over a SLOT_N-slot frame; at
//   the last slot each sum is saturated to 16 bits, formatted (YM3012-style
//   floating or linear) and serialised LSB first during the next frame,
//   channel c occupying slots c*W .. c*W+15 (W = SLOT_N/CH_N).
//
//   Ports:
//     i_EMUCLK : master clock, rising edge
//     i_MRST_n : asynchronous active-low reset
//     bus      : ika2151_mixacc_if.slave (clock enable, sync, sample bus,
//                format select, clip clear, o_SO/o_SH/o_CLIP)
module ika2151_mixacc #(
  parameter int CH_N   = 2,
  parameter int SLOT_N = 32,
  parameter int IN_W   = 14,
  parameter int ACC_W  = 19
) (
  input logic            i_EMUCLK,
  input logic            i_MRST_n,
  ika2151_mixacc_if.slave bus
);
  localparam int W  = SLOT_N / CH_N;
  localparam int SW = (SLOT_N > 1) ? $clog2(SLOT_N) : 1;
  localparam logic [SW-1:0]           SLOT_LAST = SW'(SLOT_N - 1);
  localparam logic signed [ACC_W-1:0] MAX_S     = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MIN_S     = ACC_W'(-32768);

  logic [SW-1:0]              slot_q, slot_d;
  logic [CH_N-1:0][ACC_W-1:0] acc_q,  acc_d;
  logic [CH_N-1:0][15:0]      word_q, word_d;
  logic [CH_N-1:0]            clip_q, clip_d;
  logic [CH_N-1:0]            sh_q,   sh_d;
  logic                       so_q,   so_d;

  logic             en;
  logic             snap;
  logic [ACC_W-1:0] add;
  logic [ACC_W-1:0] total;
  logic [16:0]      sat_r;
  int               pos;

  // {clamped, s}
  function automatic logic [16:0] sat16(input logic [ACC_W-1:0] t);
    if ($signed(t) > MAX_S)      return {1'b1, 16'h7FFF};
    else if ($signed(t) < MIN_S) return {1'b1, 16'h8000};
    else                         return {1'b0, t[15:0]};
  endfunction

  // Floating word: 3-bit exponent over a 10-bit offset-binary mantissa.
  // The exponent is set by how many bits below the sign repeat it (max 6).
  function automatic logic [15:0] float_word(input logic [15:0] s);
    int         lead;
    logic       run;
    logic [2:0] e;
    logic [15:0] shv;
    lead = 0;
    run  = 1'b1;
    for (int i = 14; i >= 9; i--) begin
      if (run && (s[i] == s[15])) lead = lead + 1;
      else                        run  = 1'b0;
    end
    e   = 3'(7 - lead);
    shv = 16'($signed(s) >>> (e - 3'd1));
    return {e, ~s[15], shv[8:0], 3'b000};
  endfunction

  always_comb begin
    en     = ~bus.i_CEN_n;
    snap   = en & ~bus.i_SYNC & (slot_q == SLOT_LAST);
    slot_d = slot_q;
    acc_d  = acc_q;
    word_d = word_q;
    clip_d = clip_q;
    sh_d   = sh_q;
    so_d   = so_q;
    add    = '0;
    total  = '0;
    sat_r  = '0;
    pos    = 0;
    if (en) begin
      slot_d = (bus.i_SYNC || (slot_q == SLOT_LAST)) ? '0 : slot_q + 1'b1;
      clip_d = bus.i_CLIP_CLR ? '0 : clip_q;
      for (int ch = 0; ch < CH_N; ch++) begin
        add   = (bus.i_SND_VALID && bus.i_CH_MASK[ch]) ?
                {{(ACC_W-IN_W){bus.i_SND[IN_W-1]}}, bus.i_SND} : '0;
        total = acc_q[ch] + add;
        if (bus.i_SYNC) begin
          // Realign: discard the partial frame, keep the current sample.
          acc_d[ch] = add;
        end else if (snap) begin
          acc_d[ch] = '0;
          sat_r     = sat16(total);
          // A clip on the clear edge must survive, so set after clear.
          if (sat_r[16]) clip_d[ch] = 1'b1;
          word_d[ch] = bus.i_FMT ? sat_r[15:0] : float_word(sat_r[15:0]);
        end else begin
          acc_d[ch] = total;
        end
      end
      // Outputs follow the slot and words as they stand after this edge,
      // so a freshly snapshotted word starts shifting at slot 0.
      so_d = 1'b0;
      sh_d = '0;
      for (int ch = 0; ch < CH_N; ch++) begin
        pos = int'(slot_d) - ch * W;
        if ((pos >= 0) && (pos < 16)) so_d = word_d[ch][pos[3:0]];
        if (pos == 15) sh_d[ch] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      slot_q <= '0;
      acc_q  <= '0;
      word_q <= '0;
      clip_q <= '0;
      sh_q   <= '0;
      so_q   <= 1'b0;
    end else begin
      slot_q <= slot_d;
      acc_q  <= acc_d;
      word_q <= word_d;
      clip_q <= clip_d;
      sh_q   <= sh_d;
      so_q   <= so_d;
    end
  end

  assign bus.o_SO   = so_q;
  assign bus.o_SH   = sh_q;
  assign bus.o_CLIP = clip_q;
endmodule

// File: tb/tb_ika2151_mixacc.sv
module tb_ika2151_mixacc;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] so_bits;
  logic [31:0] sh0_bits;
  logic [31:0] sh1_bits;

  ika2151_mixacc_if #(.CH_N(2), .IN_W(14)) bus ();

  ika2151_mixacc #(.CH_N(2), .SLOT_N(32), .IN_W(14), .ACC_W(19)) dut (
    .i_EMUCLK (clk),
    .i_MRST_n (rst_n),
    .bus      (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_CEN_n     = 1'b0;
    bus.i_SYNC      = 1'b0;
    bus.i_SND_VALID = 1'b0;
    bus.i_CH_MASK   = 2'b00;
    bus.i_SND       = '0;
    bus.i_CLIP_CLR  = 1'b0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Runs one 32-slot frame starting at slot 0. Captures the serial stream
  // (previous frame's words) while feeding n_samp samples from slot 0.
  task automatic run_frame(input int n_samp, input logic [1:0] mask,
                           input logic [13:0] snd, input logic fmt,
                           input int clr_slot, input int stall_slot);
    logic held;
    for (int i = 0; i < 32; i++) begin
      if (i == stall_slot) begin
        held = bus.o_SO;
        bus.i_CEN_n     = 1'b1;
        bus.i_SND_VALID = 1'b1;
        bus.i_CH_MASK   = 2'b11;
        bus.i_SND       = 14'h1000;
        bus.i_CLIP_CLR  = 1'b1;
        for (int k = 0; k < 7; k++) begin
          edge_step();
          check("stall_so", {31'b0, bus.o_SO}, {31'b0, held});
        end
        bus.i_CEN_n = 1'b0;
      end
      so_bits[i]  = bus.o_SO;
      sh0_bits[i] = bus.o_SH[0];
      sh1_bits[i] = bus.o_SH[1];
      bus.i_SND_VALID = (i < n_samp);
      bus.i_CH_MASK   = mask;
      bus.i_SND       = snd;
      bus.i_FMT       = fmt;
      bus.i_CLIP_CLR  = (i == clr_slot);
      bus.i_SYNC      = 1'b0;
      edge_step();
    end
    idle_inputs();
  endtask

  task automatic check_frame(input string tag, input logic [15:0] w0, input logic [15:0] w1);
    check({tag, "_so"},  so_bits,  {w1, w0});
    check({tag, "_sh0"}, sh0_bits, 32'h0000_8000);
    check({tag, "_sh1"}, sh1_bits, 32'h8000_0000);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bus.i_FMT = 1'b0;
    idle_inputs();
    #22;
    rst_n = 1'b1;

    check("rst_so",   {31'b0, bus.o_SO}, 32'h0);
    check("rst_sh",   {30'b0, bus.o_SH}, 32'h0);
    check("rst_clip", {30'b0, bus.o_CLIP}, 32'h0);

    // A: one 0x0100 on ch0, floating. Output still the reset (zero) words.
    run_frame(1, 2'b01, 14'h0100, 1'b0, -1, -1);
    check_frame("frm_a", 16'h0000, 16'h0000);
    // B: ch0 = m 0x300 e 1 -> 0x3800; silent ch1 floats to 0x3000.
    run_frame(4, 2'b01, 14'h1FFF, 1'b0, -1, -1);
    check_frame("frm_b", 16'h3800, 16'h3000);
    check("clip_b", {30'b0, bus.o_CLIP}, 32'h0);
    // C: 4 x 8191 = 0x7FFC -> e 7, m 0x3FF -> 0xFFF8.
    run_frame(1, 2'b01, 14'h3FFF, 1'b0, -1, -1);
    check_frame("frm_c", 16'hFFF8, 16'h3000);
    check("clip_c", {30'b0, bus.o_CLIP}, 32'h0);
    // D: -1 -> e 1, m 0x1FF -> 0x2FF8.
    run_frame(5, 2'b01, 14'h1FFF, 1'b1, -1, -1);
    check_frame("frm_d", 16'h2FF8, 16'h3000);
    check("clip_d", {30'b0, bus.o_CLIP}, 32'h1);
    // E: 5 x 8191 linear saturates to 0x7FFF; flag holds.
    run_frame(0, 2'b00, 14'h0000, 1'b1, -1, -1);
    check_frame("frm_e", 16'h7FFF, 16'h0000);
    check("clip_hold", {30'b0, bus.o_CLIP}, 32'h1);
    // F: clear mid-frame.
    run_frame(0, 2'b00, 14'h0000, 1'b1, 5, -1);
    check_frame("frm_f", 16'h0000, 16'h0000);
    check("clip_clr", {30'b0, bus.o_CLIP}, 32'h0);
    // G: clip on the same edge as a clear -> flag set.
    run_frame(5, 2'b01, 14'h1FFF, 1'b1, 31, -1);
    check_frame("frm_g", 16'h0000, 16'h0000);
    check("clip_set_wins", {30'b0, bus.o_CLIP}, 32'h1);
    // H: ch1 5 x -8192 = -40960 -> 0x8000; ch0 flag cleared at slot 0.
    run_frame(5, 2'b10, 14'h2000, 1'b1, 0, -1);
    check_frame("frm_h", 16'h7FFF, 16'h0000);
    check("clip_h", {30'b0, bus.o_CLIP}, 32'h2);
    // I: one 0x0100 on ch0, floating.
    run_frame(1, 2'b01, 14'h0100, 1'b0, -1, -1);
    check_frame("frm_i", 16'h0000, 16'h8000);

    // J: partial sums on ch0, then sync at slot 10 carrying a ch1 sample.
    for (int i = 0; i < 10; i++) begin
      bus.i_SND_VALID = (i < 4);
      bus.i_CH_MASK   = 2'b01;
      bus.i_SND       = 14'h0100;
      bus.i_FMT       = 1'b0;
      edge_step();
    end
    bus.i_SYNC      = 1'b1;
    bus.i_SND_VALID = 1'b1;
    bus.i_CH_MASK   = 2'b10;
    bus.i_SND       = 14'h0100;
    edge_step();
    idle_inputs();
    // Previous words replayed from slot 0.
    run_frame(0, 2'b00, 14'h0000, 1'b0, -1, -1);
    check_frame("frm_sync", 16'h3800, 16'h3000);
    // K: only the sync-edge sample survives; 7-edge stall at slot 12.
    run_frame(0, 2'b00, 14'h0000, 1'b0, -1, 12);
    check_frame("frm_post_sync", 16'h3000, 16'h3800);
    check("clip_stall", {30'b0, bus.o_CLIP}, 32'h2);
    // L: stall samples were not accumulated.
    run_frame(0, 2'b00, 14'h0000, 1'b0, -1, -1);
    check_frame("frm_stall", 16'h3000, 16'h3000);

    // Async reset mid-word (slot 13 carries a 1 of 0x3000).
    for (int i = 0; i < 13; i++) edge_step();
    check("pre_rst_so", {31'b0, bus.o_SO}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_so",   {31'b0, bus.o_SO}, 32'h0);
    check("mid_rst_sh",   {30'b0, bus.o_SH}, 32'h0);
    check("mid_rst_clip", {30'b0, bus.o_CLIP}, 32'h0);
    #2;
    rst_n = 1'b1;
    run_frame(0, 2'b00, 14'h0000, 1'b0, -1, -1);
    check_frame("frm_after_rst", 16'h0000, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ika2151_mixacc.md
# ika2151_mixacc

Parametrised multi-channel output accumulator and serial DAC formatter for the IKA2151 sound path. It sums per-slot operator/noise samples into CH_N channel accumulators over a SLOT_N-slot frame. It saturates each sum to 16 bits and serialises one 16-bit word per channel in the following frame, in either YM3012-style floating format or linear two's-complement format. It replaces the fixed two-channel accumulator and adds per-channel clip flags, word strobes, selectable output format and internal frame sequencing.

## Interface
- CH_N, 2: number of output channels; SLOT_N divisible by CH_N, and W = SLOT_N/CH_N ≥ 16
- SLOT_N, 32: slots per frame
- IN_W, 14: input sample width, signed two's complement
- ACC_W, 19: accumulator width; must be ≥ max(16, IN_W + clog2(SLOT_N)), so accumulators never wrap
- i_EMUCLK  in  1  master clock; all state changes on rising edge
- i_MRST_n  in  1  asynchronous active-low reset
- i_CEN_n  in  1  active-low clock enable; state advances only on edges where it is 0 ("enabled edge")
- i_SYNC  in  1  frame realign; on an enabled edge the slot counter is forced to 0
- i_FMT  in  1  0 = floating word, 1 = linear word; sampled at snapshot
- i_SND_VALID  in  1  current slot carries a sample
- i_CH_MASK  in  CH_N  per-channel add enable for the current sample
- i_SND  in  IN_W  current sample
- i_CLIP_CLR  in  1  clears all clip flags on an enabled edge
- o_SO  out  1  serial output, LSB first
- o_SH  out  CH_N  word-complete strobe per channel
- o_CLIP  out  CH_N  sticky saturation flag per channel

## Operation
- Slot counter `slot`, range 0..SLOT_N-1. On an enabled edge: if i_SYNC, slot ← 0; else slot ← (slot+1) mod SLOT_N.
- Add term for channel c: `add_c = i_SND_VALID & i_CH_MASK[c] ? sext(i_SND) : 0`.
- Enabled edge with slot == SLOT_N-1 and no i_SYNC is the snapshot edge. At that edge:
  - total_c = acc_c + add_c
  - acc_c ← 0
  - word_c ← fmt(sat(total_c))
- Enabled edge with i_SYNC: acc_c ← add_c, no snapshot, word_c is unchanged.
- Any other enabled edge: acc_c ← acc_c + add_c.
- Saturation: s = clamp(total, -32768, 32767). If clamped, o_CLIP[c] ← 1. If i_CLIP_CLR is asserted on the same edge, set wins.
- Linear word (i_FMT = 1): word = s[15:0].
- Floating word (i_FMT = 0):
  - lead = count of consecutive bits s[14], s[13], ... equal to s[15], capped at 6.
  - e = 7 - lead (1..7).
  - m[8:0] = (s >>> (e-1))[8:0]; m[9] = ~s[15] (offset-binary sign).
  - Word bits p0..p2 = 0, p3..p12 = m[0..9], p13..p15 = e[0..2].
- Serialisation: during slot t, with c = t / W and p = t mod W:
  - o_SO = word_c[p] if p < 16, else 0.
  - o_SH[c] = 1 only when p == 15.
- o_SO and o_SH are registered from the slot value that is current after the enabled edge.

## Timing
- Reset (async) clears: slot = 0, all acc = 0, all word = 0, o_SO = 0, o_SH = 0, o_CLIP = 0.
- Latency: samples of frame n are serialised in frame n+1. Channel c bit 0 appears during slot c·W of frame n+1.
- Between enabled edges, every register and output holds.
- i_SYNC mid-frame shortens that frame. The partial sums are discarded, and the previous words are re-serialised from slot 0.
- i_FMT is only sampled at snapshot, so a change mid-frame never alters the word currently being shifted.
- Reset mid-word forces o_SO = 0 immediately. No strobe is emitted until the next valid p == 15.

## Test plan
- Defaults, floating, ch0: a single sample 0x0100 with mask 01 → word_0 = m 0x300, e 1. Frame n+1 slots 0..15 carry 0,0,0, then bits of 0x300 LSB first, then 1,0,0. o_SH[0] is high during slot 15 only.
- Four samples of 8191 on mask 01 → s = 0x7FFC, e = 7, m = 0x3FF, o_CLIP = 00. One sample of 0x3FFF (-1) → e = 1, m = 0x1FF.
- Five samples of 8191, i_FMT = 1 → ch0 serial word 0x7FFF, o_CLIP[0] = 1. The flag holds until i_CLIP_CLR. A clip and a clear on the same edge leave o_CLIP[0] = 1.
- Mask 10, sample -8192 ×5 (-40960) → ch1 serial word in slots 16..31 equals linear 0x8000. Ch0 word is 0x0000 and o_SH[1] is high at slot 31.
- i_SYNC pulsed at slot 10 with nonzero partial sums → the next snapshot contains only samples from after the sync. The words shifted after the sync equal the previous frame's words.
- i_CEN_n held at 1 for 7 edges mid-frame → no change to slot, o_SO or accumulators. Async reset asserted mid-word → all outputs 0 immediately. After release, the first output is an all-zero frame.
